// File: rtl/icache_refill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_fsm
// Description : Instruction-cache miss handler. Issues one block read to DRAM
//               per miss, writes the returned block into the icache and stalls
//               fetch until the fill completes.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_fsm #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_SIZE  = 64,
    parameter int OFFSET_BITS = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_PC,
    input  logic                  recovery_PC_valid,
    input  logic                  dram_req_ready,
    output logic                  dram_req_valid,
    output logic [ADDR_WIDTH-1:0] dram_req_addr,
    input  logic                  dram_response_valid,
    input  logic [BLOCK_SIZE-1:0] dram_response,
    output logic                  icache_we,
    output logic [ADDR_WIDTH-1:0] icache_waddr,
    output logic [BLOCK_SIZE-1:0] icache_wdata,
    output logic                  fetch_stall,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_offset_mask = ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_one     = CNT_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BLOCK_SIZE-1:0] r_data;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [ADDR_WIDTH-1:0] w_pc_aligned;

    assign w_pc_aligned = miss_PC & ~c_offset_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Redirect is only honoured before the handshake; once the request is
    // accepted the returned block is still valid for r_addr and is filled.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (miss_valid)          w_next_state = S_REQ;
            S_REQ: begin
                if (recovery_PC_valid)       w_next_state = S_IDLE;
                else if (dram_req_ready)     w_next_state = S_WAIT;
            end
            S_WAIT: if (dram_response_valid) w_next_state = S_FILL;
            S_FILL:                          w_next_state = S_IDLE;
            default:                         w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            if (r_state == S_IDLE && miss_valid) begin
                r_addr <= w_pc_aligned;
            end
            if (r_state == S_WAIT && dram_response_valid) begin
                r_data <= dram_response;
            end
            if (r_state == S_FILL && r_count != '1) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    assign dram_req_valid = (r_state == S_REQ);
    assign dram_req_addr  = r_addr;
    assign icache_we      = (r_state == S_FILL);
    assign icache_waddr   = r_addr;
    assign icache_wdata   = r_data;
    assign fetch_stall    = (r_state != S_IDLE);
    assign miss_count     = r_count;

    a_no_req_and_fill : assert property (@(posedge clk) disable iff (rst)
        !(dram_req_valid && icache_we));
    a_single_cycle_fill : assert property (@(posedge clk) disable iff (rst)
        icache_we |=> !icache_we);

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_fsm
// Description : Directed self-checking bench for icache_refill_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_fsm;

    localparam int AW = 32;
    localparam int BW = 64;
    // Narrow counter so saturation is reachable with a handful of fills.
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_valid;
    logic [AW-1:0] miss_PC;
    logic          recovery_PC_valid;
    logic          dram_req_ready;
    logic          dram_req_valid;
    logic [AW-1:0] dram_req_addr;
    logic          dram_response_valid;
    logic [BW-1:0] dram_response;
    logic          icache_we;
    logic [AW-1:0] icache_waddr;
    logic [BW-1:0] icache_wdata;
    logic          fetch_stall;
    logic [CW-1:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    icache_refill_fsm #(
        .ADDR_WIDTH (AW),
        .BLOCK_SIZE (BW),
        .OFFSET_BITS(3),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .miss_valid         (miss_valid),
        .miss_PC            (miss_PC),
        .recovery_PC_valid  (recovery_PC_valid),
        .dram_req_ready     (dram_req_ready),
        .dram_req_valid     (dram_req_valid),
        .dram_req_addr      (dram_req_addr),
        .dram_response_valid(dram_response_valid),
        .dram_response      (dram_response),
        .icache_we          (icache_we),
        .icache_waddr       (icache_waddr),
        .icache_wdata       (icache_wdata),
        .fetch_stall        (fetch_stall),
        .miss_count         (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Minimum-latency miss: enters in IDLE, returns in the first IDLE cycle after FILL.
    task automatic do_fill(input logic [AW-1:0] pc, input logic [BW-1:0] data);
        miss_valid = 1'b1; miss_PC = pc; dram_req_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        check_eq("fill_req_addr", 64'(dram_req_addr), 64'(pc & ~32'h7));
        step();
        dram_response_valid = 1'b1; dram_response = data;
        step();
        dram_response_valid = 1'b0;
        check_eq("fill_we", 64'(icache_we), 64'd1);
        check_eq("fill_wdata", icache_wdata, data);
        step();
    endtask

    initial begin
        // T1: reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            miss_valid          = 1'($urandom);
            miss_PC             = $urandom;
            recovery_PC_valid   = 1'($urandom);
            dram_req_ready      = 1'($urandom);
            dram_response_valid = 1'($urandom);
            dram_response       = {$urandom, $urandom};
            step();
        end
        check_eq("rst_req_valid", 64'(dram_req_valid), 64'd0);
        check_eq("rst_req_addr", 64'(dram_req_addr), 64'd0);
        check_eq("rst_we", 64'(icache_we), 64'd0);
        check_eq("rst_waddr", 64'(icache_waddr), 64'd0);
        check_eq("rst_wdata", icache_wdata, 64'd0);
        check_eq("rst_stall", 64'(fetch_stall), 64'd0);
        check_eq("rst_count", 64'(miss_count), 64'd0);
        rst = 1'b0;
        miss_valid = 1'b0; miss_PC = '0; recovery_PC_valid = 1'b0;
        dram_req_ready = 1'b0; dram_response_valid = 1'b0; dram_response = '0;
        step();

        // T2: basic miss
        miss_valid = 1'b1; miss_PC = 32'h0000_1234; dram_req_ready = 1'b1;
        check_eq("t2_stall_t0", 64'(fetch_stall), 64'd0);
        step();                                            // t1
        miss_valid = 1'b0;
        check_eq("t2_req_valid", 64'(dram_req_valid), 64'd1);
        check_eq("t2_req_addr", 64'(dram_req_addr), 64'h1230);
        check_eq("t2_stall_t1", 64'(fetch_stall), 64'd1);
        step();                                            // t2
        dram_req_ready = 1'b0;
        check_eq("t2_req_drop", 64'(dram_req_valid), 64'd0);
        step();                                            // t3
        step();                                            // t4
        check_eq("t2_stall_t4", 64'(fetch_stall), 64'd1);
        dram_response_valid = 1'b1; dram_response = 64'hDEAD_BEEF_CAFE_F00D;
        step();                                            // t5
        dram_response_valid = 1'b0;
        check_eq("t2_we", 64'(icache_we), 64'd1);
        check_eq("t2_waddr", 64'(icache_waddr), 64'h1230);
        check_eq("t2_wdata", icache_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        check_eq("t2_stall_t5", 64'(fetch_stall), 64'd1);
        check_eq("t2_no_req_in_fill", 64'(dram_req_valid), 64'd0);
        step();                                            // t6
        check_eq("t2_we_low", 64'(icache_we), 64'd0);
        check_eq("t2_stall_t6", 64'(fetch_stall), 64'd0);
        check_eq("t2_count", 64'(miss_count), 64'd1);

        // T3: backpressure in REQ
        miss_valid = 1'b1; miss_PC = 32'h0000_ABCF; dram_req_ready = 1'b0;
        step();
        miss_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_hold_valid", 64'(dram_req_valid), 64'd1);
            check_eq("t3_hold_addr", 64'(dram_req_addr), 64'hABC8);
            step();
        end
        check_eq("t3_still_req", 64'(dram_req_valid), 64'd1);
        dram_req_ready = 1'b1;
        step();
        dram_req_ready = 1'b0;
        check_eq("t3_wait_valid", 64'(dram_req_valid), 64'd0);
        check_eq("t3_wait_stall", 64'(fetch_stall), 64'd1);
        dram_response_valid = 1'b1; dram_response = 64'h0123_4567_89AB_CDEF;
        step();
        dram_response_valid = 1'b0;
        check_eq("t3_we", 64'(icache_we), 64'd1);
        check_eq("t3_waddr", 64'(icache_waddr), 64'hABC8);
        step();
        check_eq("t3_count", 64'(miss_count), 64'd2);

        // T4: squash in REQ (redirect beats ready)
        miss_valid = 1'b1; miss_PC = 32'h0000_0104;
        step();
        miss_valid = 1'b0;
        recovery_PC_valid = 1'b1; dram_req_ready = 1'b1;
        check_eq("t4_req_valid", 64'(dram_req_valid), 64'd1);
        step();
        recovery_PC_valid = 1'b0; dram_req_ready = 1'b0;
        check_eq("t4_idle_stall", 64'(fetch_stall), 64'd0);
        check_eq("t4_idle_valid", 64'(dram_req_valid), 64'd0);
        check_eq("t4_count", 64'(miss_count), 64'd2);
        dram_response_valid = 1'b1; dram_response = 64'hFFFF_0000_FFFF_0000;

        // T5: spurious response while IDLE, then redirect during WAIT
        step();
        dram_response_valid = 1'b0;
        check_eq("t5_spur_we", 64'(icache_we), 64'd0);
        check_eq("t5_spur_stall", 64'(fetch_stall), 64'd0);
        miss_valid = 1'b1; miss_PC = 32'h0000_2004; dram_req_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        step();
        dram_req_ready = 1'b0; recovery_PC_valid = 1'b1;
        step();
        check_eq("t5_wait_held", 64'(fetch_stall), 64'd1);
        check_eq("t5_wait_we", 64'(icache_we), 64'd0);
        dram_response_valid = 1'b1; dram_response = 64'h5555_AAAA_5555_AAAA;
        step();
        dram_response_valid = 1'b0; recovery_PC_valid = 1'b0;
        check_eq("t5_we", 64'(icache_we), 64'd1);
        check_eq("t5_waddr", 64'(icache_waddr), 64'h2000);
        check_eq("t5_wdata", icache_wdata, 64'h5555_AAAA_5555_AAAA);
        step();
        check_eq("t5_we_once", 64'(icache_we), 64'd0);
        check_eq("t5_count", 64'(miss_count), 64'd3);

        // T6: back-to-back fills up to saturation
        for (int i = 0; i < 12; i++) begin
            do_fill(32'h0000_4000 + 32'(i * 8) + 32'(i % 8), {32'(i), 32'hC0DE_0000 + 32'(i)});
        end
        check_eq("t6_count_max", 64'(miss_count), 64'hF);
        do_fill(32'h0000_8007, 64'h1111_2222_3333_4444);
        check_eq("t6_count_sat", 64'(miss_count), 64'hF);

        // Simultaneous miss and redirect in IDLE: miss latched, then squashed in REQ
        miss_valid = 1'b1; recovery_PC_valid = 1'b1; miss_PC = 32'h0000_9ABF;
        dram_req_ready = 1'b0;
        step();
        miss_valid = 1'b0;
        check_eq("t6_sim_req", 64'(dram_req_valid), 64'd1);
        check_eq("t6_sim_addr", 64'(dram_req_addr), 64'h9AB8);
        step();
        recovery_PC_valid = 1'b0;
        check_eq("t6_sim_squash", 64'(fetch_stall), 64'd0);

        // Reset while waiting for DRAM; the late response must not fill
        miss_valid = 1'b1; miss_PC = 32'h0000_C000; dram_req_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        step();
        dram_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_rst_stall", 64'(fetch_stall), 64'd0);
        check_eq("t6_rst_count", 64'(miss_count), 64'd0);
        dram_response_valid = 1'b1; dram_response = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        dram_response_valid = 1'b0;
        check_eq("t6_late_we", 64'(icache_we), 64'd0);
        check_eq("t6_late_stall", 64'(fetch_stall), 64'd0);
        step();
        check_eq("t6_late_we2", 64'(icache_we), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
